// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage data-access engine. Takes a decoded access request and drives a
// synchronous data memory (read data valid one cycle after dm_re). Word stores
// complete in one cycle, loads in two, and sub-word stores use read-modify-write
// over three cycles.
//
// Ports
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   mem_en/we/size/sext request valid, store/load, size (00 B, 01 H, 10 W), sign-extend
//   mem_addr, mem_wdata byte address, right-justified store data
//   dm_addr/re/we/wdata word-aligned memory address, read/write strobes, write data
//   dm_rdata           memory read data
//   ld_data, ld_valid  registered extended load result and its one-cycle pulse
//   stall              upstream must hold the request while high
//   GCnt               high during the write phase of a sub-word store
//   align_err          one-cycle pulse after a misaligned or reserved request
//
// state   | meaning
// IDLE    | accept request; word stores finish here
// LD_WAIT | memory data present, extend and register load result
// RMW_RD  | memory data present, merge store lane(s) into it
// RMW_WR  | write merged word back
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          mem_en,
  input  logic          mem_we,
  input  logic [1:0]    mem_size,
  input  logic          mem_sext,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] dm_addr,
  output logic          dm_re,
  output logic          dm_we,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  output logic [DW-1:0] ld_data,
  output logic          ld_valid,
  output logic          stall,
  output logic          GCnt,
  output logic          align_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LD_WAIT = 2'd1;
  localparam logic [1:0] S_RMW_RD  = 2'd2;
  localparam logic [1:0] S_RMW_WR  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          ld_valid_q, ld_valid_d;
  logic          align_err_q, align_err_d;
  logic [DW-1:0] merge_q, merge_d;

  logic          misaligned;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] merged;

  assign dm_addr = {mem_addr[AW-1:2], 2'b00};

  assign misaligned = (mem_size == 2'b11) ||
                      (mem_size == 2'b01 && mem_addr[0]) ||
                      (mem_size == 2'b10 && mem_addr[1:0] != 2'b00);

  // Lane extraction from the read word (little-endian lanes)
  assign byte_sel = dm_rdata[{mem_addr[1:0], 3'b000} +: 8];
  assign half_sel = dm_rdata[{mem_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (mem_size)
      2'b00:   load_ext = {{24{mem_sext & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{mem_sext & half_sel[15]}}, half_sel};
      default: load_ext = dm_rdata;
    endcase
  end

  // Store lane(s) overlaid on the word read back from memory
  always_comb begin
    merged = dm_rdata;
    case (mem_size)
      2'b00:   merged[{mem_addr[1:0], 3'b000} +: 8] = mem_wdata[7:0];
      2'b01:   merged[{mem_addr[1], 4'b0000} +: 16] = mem_wdata[15:0];
      default: merged = dm_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_data_d   = ld_data_q;
    ld_valid_d  = 1'b0;
    align_err_d = 1'b0;
    merge_d     = merge_q;
    dm_re       = 1'b0;
    dm_we       = 1'b0;
    dm_wdata    = mem_wdata;
    stall       = 1'b0;
    GCnt        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          if (misaligned) begin
            align_err_d = 1'b1;
          end else if (mem_we && mem_size == 2'b10) begin
            dm_we = 1'b1;
          end else begin
            dm_re   = 1'b1;
            stall   = 1'b1;
            state_d = mem_we ? S_RMW_RD : S_LD_WAIT;
          end
        end
      end
      S_LD_WAIT: begin
        ld_data_d  = load_ext;
        ld_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_RMW_RD: begin
        merge_d = merged;
        stall   = 1'b1;
        state_d = S_RMW_WR;
      end
      default: begin
        dm_we    = 1'b1;
        dm_wdata = merge_q;
        GCnt     = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
    // Strobes must drop the instant reset asserts, not at the next edge
    if (RST) begin
      dm_re = 1'b0;
      dm_we = 1'b0;
      stall = 1'b0;
      GCnt  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ld_data_q   <= '0;
      ld_valid_q  <= 1'b0;
      align_err_q <= 1'b0;
      merge_q     <= '0;
    end else begin
      state_q     <= state_d;
      ld_data_q   <= ld_data_d;
      ld_valid_q  <= ld_valid_d;
      align_err_q <= align_err_d;
      merge_q     <= merge_d;
    end
  end

  assign ld_data   = ld_data_q;
  assign ld_valid  = ld_valid_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mem_en = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_sext = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] dm_addr;
  logic        dm_re;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        stall;
  logic        GCnt;
  logic        align_err;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_sext(mem_sext),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .ld_data(ld_data), .ld_valid(ld_valid), .stall(stall), .GCnt(GCnt),
    .align_err(align_err)
  );

  always #5 CLK = ~CLK;

  // Synchronous data memory seen by the DUT
  logic [31:0] mem [0:1023];
  always @(posedge CLK) begin
    if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;
    if (dm_re) dm_rdata <= mem[dm_addr[11:2]];
  end

  // Reference model state
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int exp_align = 0;
  int got_align = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_bad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    logic [31:0] w, v;
    int sh;
    w = ref_mem[a[11:2]];
    if (sz == 2'b00) begin
      sh = int'(a[1:0]) * 8;
      v = (w >> sh) & 32'hFF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      sh = int'(a[1]) * 16;
      v = (w >> sh) & 32'hFFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w, m;
    int sh;
    w = ref_mem[a[11:2]];
    if (sz == 2'b00) begin
      sh = int'(a[1:0]) * 8;
      m = 32'hFF << sh;
      w = (w & ~m) | ((d & 32'hFF) << sh);
    end else if (sz == 2'b01) begin
      sh = int'(a[1]) * 16;
      m = 32'hFFFF << sh;
      w = (w & ~m) | ((d & 32'hFFFF) << sh);
    end else begin
      w = d;
    end
    ref_mem[a[11:2]] = w;
  endfunction

  // Records what the request should produce, in issue order
  task automatic expect_req(input logic we, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] d);
    if (is_bad(sz, a)) exp_align++;
    else if (we) ref_store(a, sz, d);
    else exp_q.push_back(ref_load(a, sz, sx));
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    mem_en = 1'b1; mem_we = we; mem_size = sz; mem_sext = sx;
    mem_addr = a; mem_wdata = d;
  endtask

  // Present a request at the falling edge and hold it until an edge with stall low
  task automatic req(input logic we, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] d);
    bit done;
    bit s;
    done = 1'b0;
    @(negedge CLK);
    drive(we, sz, sx, a, d);
    expect_req(we, sz, sx, a, d);
    for (int c = 0; c < 6 && !done; c++) begin
      #1;
      s = stall;
      @(posedge CLK);
      if (!s) done = 1'b1;
    end
    if (!done) begin
      bad++;
      total++;
      $display("FAIL req_timeout: stall still high after 6 cycles at addr %h", a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      mem_en = 1'b0;
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (ld_valid) begin
      if (exp_q.size() == 0) begin
        bad++;
        total++;
        $display("FAIL ld_unexpected: got ld_valid with data %h, required no load", ld_data);
      end else begin
        chk("ld_data", ld_data, exp_q.pop_front());
      end
    end
    if (align_err) got_align++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0] sz;
    logic we, sx;

    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("rst_ld_valid", {31'b0, ld_valid}, 32'h0);
    chk("rst_align_err", {31'b0, align_err}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    RST = 1'b0;

    // Word store, same-cycle write, no stall
    @(negedge CLK);
    drive(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344);
    expect_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344);
    #1;
    chk("wst_dm_we", {31'b0, dm_we}, 32'h1);
    chk("wst_dm_addr", dm_addr, 32'h100);
    chk("wst_dm_wdata", dm_wdata, 32'h1122_3344);
    chk("wst_stall", {31'b0, stall}, 32'h0);
    @(posedge CLK);

    // Word load with exact latency
    @(negedge CLK);
    drive(1'b0, 2'b10, 1'b1, 32'h100, 32'h0);
    exp_q.push_back(32'h1122_3344);
    #1;
    chk("ld_c0_re", {31'b0, dm_re}, 32'h1);
    chk("ld_c0_stall", {31'b0, stall}, 32'h1);
    @(posedge CLK); #1;
    chk("ld_c1_stall", {31'b0, stall}, 32'h0);
    chk("ld_c1_valid", {31'b0, ld_valid}, 32'h0);
    @(posedge CLK); #1;
    mem_en = 1'b0;
    chk("ld_c2_valid", {31'b0, ld_valid}, 32'h1);
    chk("ld_c2_data", ld_data, 32'h1122_3344);

    // Byte store RMW timing
    @(negedge CLK);
    drive(1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_00AB);
    expect_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h0000_00AB);
    #1;
    chk("rmw_c0_re", {31'b0, dm_re}, 32'h1);
    chk("rmw_c0_stall", {31'b0, stall}, 32'h1);
    @(posedge CLK); #1;
    chk("rmw_c1_stall", {31'b0, stall}, 32'h1);
    chk("rmw_c1_gcnt", {31'b0, GCnt}, 32'h0);
    @(posedge CLK); #1;
    chk("rmw_c2_gcnt", {31'b0, GCnt}, 32'h1);
    chk("rmw_c2_we", {31'b0, dm_we}, 32'h1);
    chk("rmw_c2_wdata", dm_wdata, 32'h11AB_3344);
    chk("rmw_c2_stall", {31'b0, stall}, 32'h0);
    @(posedge CLK); #1;
    mem_en = 1'b0;
    chk("rmw_mem", mem[32'h102 >> 2], 32'h11AB_3344);
    req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);

    // Extension cases on 0x80FF0000
    req(1'b1, 2'b10, 1'b0, 32'h104, 32'h80FF_0000);
    @(negedge CLK); mem_en = 1'b0;
    exp_q.push_back(32'hFFFF_FF80);
    @(negedge CLK); drive(1'b0, 2'b00, 1'b1, 32'h107, 32'h0);
    repeat (2) @(posedge CLK);
    exp_q.push_back(32'h0000_80FF);
    @(negedge CLK); drive(1'b0, 2'b01, 1'b0, 32'h106, 32'h0);
    repeat (2) @(posedge CLK);
    exp_q.push_back(32'h0000_0000);
    @(negedge CLK); drive(1'b0, 2'b01, 1'b1, 32'h104, 32'h0);
    repeat (2) @(posedge CLK);
    idle(2);

    // Misaligned halfword store, then immediate next request
    @(negedge CLK);
    drive(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000_BEEF);
    expect_req(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000_BEEF);
    #1;
    chk("mis_re", {31'b0, dm_re}, 32'h0);
    chk("mis_we", {31'b0, dm_we}, 32'h0);
    chk("mis_stall", {31'b0, stall}, 32'h0);
    @(posedge CLK); #1;
    chk("mis_pulse", {31'b0, align_err}, 32'h1);
    req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    #1;
    chk("mis_pulse_end", {31'b0, align_err}, 32'h0);

    // Reset during RMW_RD
    @(negedge CLK);
    drive(1'b1, 2'b00, 1'b0, 32'h105, 32'h0000_0055);
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    chk("rst_rmw_stall", {31'b0, stall}, 32'h0);
    chk("rst_rmw_we", {31'b0, dm_we}, 32'h0);
    chk("rst_rmw_gcnt", {31'b0, GCnt}, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rmw_ldv", {31'b0, ld_valid}, 32'h0);
    @(negedge CLK);
    mem_en = 1'b0;
    RST = 1'b0;
    chk("rst_rmw_mem", mem[32'h104 >> 2], 32'h80FF_0000);
    req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);

    // Back-to-back store then load
    req(1'b1, 2'b10, 1'b0, 32'h200, 32'h1234_5678);
    req(1'b1, 2'b01, 1'b0, 32'h200, 32'hFFFF_BEEF);
    req(1'b0, 2'b01, 1'b0, 32'h200, 32'h0);
    req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    req(1'b1, 2'b01, 1'b1, 32'h202, 32'h0000_8001);
    req(1'b0, 2'b01, 1'b1, 32'h202, 32'h0);
    idle(1);

    // Randomized traffic over a small window
    for (int i = 0; i < 16; i++) req(1'b1, 2'b10, 1'b0, 32'h300 + i * 4, $urandom);
    for (int i = 0; i < 250; i++) begin
      a  = 32'h300 + $urandom_range(0, 63);
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      d  = $urandom;
      req(we, sz, sx, a, d);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(6);

    chk("queue_empty", exp_q.size(), 32'h0);
    chk("align_count", got_align, exp_align);
    for (int i = 32'h300 >> 2; i < (32'h340 >> 2); i++) chk("mem_word", mem[i], ref_mem[i]);
    chk("mem_100", mem[32'h100 >> 2], ref_mem[32'h100 >> 2]);
    chk("mem_200", mem[32'h200 >> 2], ref_mem[32'h200 >> 2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-access engine that sits directly downstream of the memory-stage control decoder. It consumes the decoded access request (enable, direction, size, sign-extension) plus address and store data, and drives the synchronous data memory. It performs word, halfword and byte accesses, including read-modify-write for sub-word stores, and returns sign- or zero-extended load data. While a multi-cycle access is in progress it asserts `stall` and exports `GCnt`, which the decoder uses as its second-phase flag.

## Interface
- `AW`, 32, byte address width
- `DW`, 32, data width (fixed at 32; lane logic assumes 4 byte lanes)

- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `mem_en`  in  1  access request valid this cycle
- `mem_we`  in  1  1 = store, 0 = load
- `mem_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as no access, `align_err`)
- `mem_sext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `mem_addr`  in  AW  byte address
- `mem_wdata`  in  DW  store data, right-justified for sub-word
- `dm_addr`  out  AW  word-aligned memory address (`mem_addr` with [1:0] = 00)
- `dm_re`  out  1  memory read strobe; `dm_rdata` valid the following cycle
- `dm_we`  out  1  memory write strobe, whole word written at the clock edge
- `dm_wdata`  out  DW  memory write data
- `dm_rdata`  in  DW  memory read data
- `ld_data`  out  DW  extended load result, registered
- `ld_valid`  out  1  one-cycle pulse: `ld_data` updated
- `stall`  out  1  hold upstream; request inputs must stay stable while high
- `GCnt`  out  1  high during the write phase of a sub-word store
- `align_err`  out  1  one-cycle registered pulse on a misaligned or reserved request

## Operation
- Little-endian lanes: byte lane = `mem_addr[1:0]`, halfword lane = `mem_addr[1]`.
- Alignment: a halfword with `addr[0]=1`, a word with `addr[1:0]!=0`, or size 11 results in no memory strobe, `align_err` pulsed in the next cycle, `stall`=0, and the state remains IDLE.
- FSM states: IDLE, LD_WAIT, RMW_RD, RMW_WR.
- In IDLE with `mem_en`=0: all strobes are 0 and `stall`=0.
- IDLE, word store: `dm_we`=1 and `dm_wdata`=`mem_wdata` in the same cycle; `stall`=0; the state remains IDLE.
- IDLE, load: `dm_re`=1 and `stall`=1, then go to LD_WAIT.
- LD_WAIT: select the lane from `dm_rdata` and extend per `mem_sext`. On the edge, register the result into `ld_data` and set `ld_valid`. `stall`=0, then go to IDLE.
- IDLE, sub-word store: `dm_re`=1 and `stall`=1, then go to RMW_RD.
- RMW_RD: merge the store lane(s) of `mem_wdata` into `dm_rdata` and capture the result in the merge register. `stall`=1, then go to RMW_WR.
- RMW_WR: `dm_we`=1, `dm_wdata`=merge register, `GCnt`=1, `stall`=0, then go to IDLE.
- Word loads ignore `mem_sext`.
- `dm_addr` is combinational from `mem_addr` in all states; inputs are held by `stall`.

## Timing
- Reset values: state IDLE; `ld_data`=0, `ld_valid`=0, `align_err`=0, merge register = 0.
- Reset is asynchronous, so `dm_we`, `dm_re`, `GCnt` and `stall` drop to 0 immediately when RST asserts.
- Reset mid-RMW: the write never occurs and memory is unchanged. Reset mid-load: `ld_valid` is never raised.
- Word store: 1 cycle, no stall.
- Load: 2 cycles. `stall` is high in cycle 0; `ld_data`/`ld_valid` are visible in cycle 2 (the first cycle after the LD_WAIT edge).
- Sub-word store: 3 cycles. `stall` is high in cycles 0–1; `GCnt` and the write happen in cycle 2.
- Upstream advances on every edge where `stall`=0; a new request may be accepted in the cycle after LD_WAIT/RMW_WR with no bubble.
- `ld_valid` and `align_err` are each high for exactly one cycle per event.
- `mem_en` seen in a non-IDLE state is part of the held request; no new request is sampled there.

## Test plan
- Word store to 0x100 with `mem_wdata`=0x11223344 → `dm_we`=1 in the same cycle, `dm_addr`=0x100, `stall` never high; then a word load of 0x100 → `ld_data`=0x11223344 with `ld_valid` two cycles after the request.
- Byte store of 0xAB to 0x102 over word 0x11223344 → `dm_re` in cycle 0, `stall` high in cycles 0–1, `GCnt`=1 and `dm_wdata`=0x11AB3344 in cycle 2; memory then reads 0x11AB3344.
- With the word at 0x104 = 0x80FF0000: signed byte load of 0x107 → 0xFFFFFF80; unsigned halfword load of 0x106 → 0x000080FF; signed halfword load of 0x104 → 0x00000000.
- Halfword store to 0x101 → no `dm_re`/`dm_we`, `align_err` pulse one cycle later, `stall`=0, and the next request is accepted immediately.
- Assert RST during RMW_RD of a byte store → `stall`/`dm_we` drop at once, state IDLE, memory word unchanged, `ld_valid`=0.
- Back-to-back: a halfword store to 0x200, then a load of 0x200 issued on the cycle `stall` falls → the load returns the merged word lane, with no request lost or duplicated.
